// File: rtl/rx_fifo_param_pkg.sv
// Shared constants, helper function and flag bundle type for the
// parametrised receive FIFO.
package rx_fifo_pkg;

  localparam int RX_DATA_W = 8;
  localparam int RX_DEPTH  = 8;

  // Pointer width needed to address 'depth' entries.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Status flag bundle presented by the FIFO.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } rx_flags_t;

endpackage

// File: rtl/rx_fifo_param_if.sv
// Handshake and status bundle between the FIFO and its producer/consumer.
interface rx_fifo_param_if
  import rx_fifo_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = RX_DEPTH
);

  localparam int CNT_W = ptr_w(DEPTH) + 1;

  logic              flush;
  logic              w_enable;
  logic [DATA_W-1:0] w_data;
  logic              r_enable;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, w_enable, w_data, r_enable,
    input  r_data, empty, full, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, w_enable, w_data, r_enable,
    output r_data, empty, full, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/rx_fifo_param_mem.sv
// DATA_W x DEPTH register file: synchronous write port, asynchronous read
// port. Contents are deliberately not reset.
module rx_fifo_mem
  import rx_fifo_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = RX_DEPTH,
  parameter int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Store the write word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/rx_fifo_param.sv
// Parametrised single-clock receive FIFO with first-word-fall-through read,
// occupancy count, programmable almost flags, sticky error flags and a
// synchronous flush.
module rx_fifo_param
  import rx_fifo_pkg::*;
#(
  parameter int DATA_W   = RX_DATA_W,
  parameter int DEPTH    = RX_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          rst,
  rx_fifo_param_if.slave bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  // Elaboration-time parameter legality.
  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("rx_fifo_param: DEPTH must be a power of two in 2..256");
  end
  if ((DATA_W < 1) || (DATA_W > 64)) begin : g_bad_width
    $error("rx_fifo_param: DATA_W must be in 1..64");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
    $error("rx_fifo_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic              underflow_r;

  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              ovf_evt_s;
  logic              udf_evt_s;
  logic [DATA_W-1:0] mem_rdata_s;
  rx_flags_t         flags_s;

  // Status flags decoded from the count register and sticky error bits.
  always_comb begin
    flags_s              = '0;
    flags_s.empty        = (count_r == {CNT_W{1'b0}});
    flags_s.full         = (count_r == DEPTH_C);
    flags_s.almost_full  = (count_r >= AF_C);
    flags_s.almost_empty = (count_r <= AE_C);
    flags_s.overflow     = overflow_r;
    flags_s.underflow    = underflow_r;
  end

  // Accept/reject decisions; flush masks both strobes and their error events.
  always_comb begin
    wr_ok_s   = 1'b0;
    rd_ok_s   = 1'b0;
    ovf_evt_s = 1'b0;
    udf_evt_s = 1'b0;
    if (bus.flush) begin
      wr_ok_s   = 1'b0;
      rd_ok_s   = 1'b0;
      ovf_evt_s = 1'b0;
      udf_evt_s = 1'b0;
    end else begin
      // A full FIFO still takes a write when a read frees a slot that cycle.
      wr_ok_s   = bus.w_enable && (!flags_s.full || bus.r_enable);
      rd_ok_s   = bus.r_enable && !flags_s.empty;
      ovf_evt_s = bus.w_enable && flags_s.full && !bus.r_enable;
      udf_evt_s = bus.r_enable && flags_s.empty;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r      <= {PTR_W{1'b0}};
      rptr_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.flush) begin
      wptr_r      <= {PTR_W{1'b0}};
      rptr_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end
      if (udf_evt_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok_s),
    .waddr (wptr_r),
    .wdata (bus.w_data),
    .raddr (rptr_r),
    .rdata (mem_rdata_s)
  );

  assign bus.r_data       = flags_s.empty ? {DATA_W{1'b0}} : mem_rdata_s;
  assign bus.count        = count_r;
  assign bus.empty        = flags_s.empty;
  assign bus.full         = flags_s.full;
  assign bus.almost_full  = flags_s.almost_full;
  assign bus.almost_empty = flags_s.almost_empty;
  assign bus.overflow     = flags_s.overflow;
  assign bus.underflow    = flags_s.underflow;

endmodule
